// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ single-beat read/write requesters.
// RAM strobes are registered; read data returns with a one-cycle strobe to the owner.
module ram_port_arbiter #(
    parameter int NREQ   = 4,
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              ram_we,
    output logic              ram_re,
    output logic [AW-1:0]     ram_addr,
    output logic [DW-1:0]     ram_di,
    input  logic [DW-1:0]     ram_do
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ram_we_q, ram_we_d;
    logic            ram_re_q, ram_re_d;
    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic [DW-1:0]   ram_di_q, ram_di_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic            win_found_s;
    logic [PW-1:0]   win_idx_s;

    // Round-robin search: first valid requester at or above ptr, wrapping modulo NREQ.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found_s && req_valid[(int'(ptr_q) + k) % NREQ]) begin
                win_found_s = 1'b1;
                win_idx_s   = PW'((int'(ptr_q) + k) % NREQ);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Grant is combinational and forced low while reset is asserted.
    always_comb begin
        req_ready = '0;
        if ((state_q == IDLE) && rst_n && win_found_s) begin
            req_ready[win_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state and datapath decode.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        ram_we_d    = 1'b0;
        ram_re_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_di_d    = ram_di_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (req_ready != '0) begin
                    ram_we_d   = req_we[win_idx_s];
                    ram_re_d   = !req_we[win_idx_s];
                    ram_addr_d = req_addr[win_idx_s*AW +: AW];
                    ram_di_d   = req_wdata[win_idx_s*DW +: DW];
                    gnt_d      = win_idx_s;
                    if (win_idx_s == PW'(NREQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = win_idx_s + PW'(1);
                    end
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (ram_we_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = CW'(RD_LAT);
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    rsp_valid_d[gnt_q] = 1'b1;
                    rsp_rdata_d        = ram_do;
                    state_d            = IDLE;
                end else begin
                    state_d = WAIT_RD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            cnt_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_di_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            ram_we_q    <= ram_we_d;
            ram_re_q    <= ram_re_d;
            ram_addr_q  <= ram_addr_d;
            ram_di_q    <= ram_di_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_re    = ram_re_q;
    assign ram_addr  = ram_addr_q;
    assign ram_di    = ram_di_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
